// File: rtl/bp_nonsynth_cosim_pkg.sv
// rtl/bp_nonsynth_cosim_pkg.sv - shared types and constants for the commit matcher
//
// Purpose: retire record layout, register-file channel indices and the rd
// field location inside a RISC-V instruction word.
package bp_nonsynth_cosim_pkg;

    localparam int rf_int_gp    = 0;
    localparam int rf_fp_gp     = 1;
    localparam int rd_offset_gp = 7;
    localparam int rd_width_gp  = 5;
    localparam int num_regs_gp  = 32;

    // Upper bounds for the fields that are parameter-sized in the matcher;
    // the matcher zero-extends into and slices out of these.
    localparam int max_vaddr_gp = 64;
    localparam int max_rf_gp    = 8;

    typedef struct packed {
        logic                    trap;
        logic                    debug;
        logic [63:0]             cause;
        logic [31:0]             instr;
        logic [max_vaddr_gp-1:0] pc;
        logic [max_rf_gp-1:0]    wb;
    } retire_rec_s;

    function automatic logic [rd_width_gp-1:0] get_rd(input logic [31:0] instr);
        return instr[rd_offset_gp +: rd_width_gp];
    endfunction

endpackage

// File: rtl/bp_nonsynth_wb_bank.sv
// rtl/bp_nonsynth_wb_bank.sv - 32 per-register writeback FIFOs for one register file
//
// Ports:
//   clk_i, reset_i      clock, asynchronous active-low reset
//   push_v/addr/data    writeback to enqueue on FIFO[push_addr]
//   pop_v               dequeue FIFO[head_addr] (ignored if empty)
//   head_addr           register whose FIFO head is presented
//   head_v, head_data   FIFO[head_addr] non-empty flag and head entry
//   overflow            pulse: push dropped because the FIFO was full
//   pending             any of the 32 FIFOs non-empty
module bp_nonsynth_wb_bank
    import bp_nonsynth_cosim_pkg::*;
#(
    parameter int wb_els_p     = 16,
    parameter int data_width_p = 64
) (
    input  logic                    clk_i,
    input  logic                    reset_i,
    input  logic                    push_v,
    input  logic [4:0]              push_addr,
    input  logic [data_width_p-1:0] push_data,
    input  logic                    pop_v,
    input  logic [4:0]              head_addr,
    output logic                    head_v,
    output logic [data_width_p-1:0] head_data,
    output logic                    overflow,
    output logic                    pending
);

    localparam int ptr_w = (wb_els_p > 1) ? $clog2(wb_els_p) : 1;
    localparam int cnt_w = $clog2(wb_els_p + 1);

    logic [num_regs_gp-1:0]  nonempty;
    logic [num_regs_gp-1:0]  drop;
    logic [data_width_p-1:0] head_arr [num_regs_gp];

    for (genvar g = 0; g < num_regs_gp; g++) begin : reg_q
        logic [ptr_w-1:0]        wr_ptr, rd_ptr;
        logic [cnt_w-1:0]        count;
        logic [data_width_p-1:0] mem [wb_els_p];
        logic                    sel_push, sel_pop, full, do_push;

        assign sel_push = push_v & (push_addr == 5'(g));
        assign sel_pop  = pop_v & (head_addr == 5'(g)) & (count != '0);
        assign full     = (count == cnt_w'(wb_els_p));
        // A pop frees the slot in the same cycle, so a full FIFO still accepts.
        assign do_push  = sel_push & (~full | sel_pop);

        assign drop[g]     = sel_push & full & ~sel_pop;
        assign nonempty[g] = (count != '0);
        assign head_arr[g] = mem[rd_ptr];

        always_ff @(posedge clk_i) begin
            if (do_push) mem[wr_ptr] <= push_data;
        end

        always_ff @(posedge clk_i or negedge reset_i) begin
            if (!reset_i) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
                count  <= '0;
            end else begin
                if (do_push)
                    wr_ptr <= (wr_ptr == ptr_w'(wb_els_p - 1)) ? '0 : wr_ptr + ptr_w'(1);
                if (sel_pop)
                    rd_ptr <= (rd_ptr == ptr_w'(wb_els_p - 1)) ? '0 : rd_ptr + ptr_w'(1);
                if (do_push & ~sel_pop)
                    count <= count + cnt_w'(1);
                else if (~do_push & sel_pop)
                    count <= count - cnt_w'(1);
            end
        end
    end

    assign head_v    = nonempty[head_addr];
    assign head_data = head_arr[head_addr];
    assign overflow  = |drop;
    assign pending   = |nonempty;

endmodule

// File: rtl/bp_nonsynth_commit_matcher.sv
// rtl/bp_nonsynth_commit_matcher.sv - pairs retired instructions with their rd writebacks
//
// Purpose: queues commit records and per-register writebacks, presents a
// record on ret_* once its writeback (if any) has arrived, and keeps an
// instruction counter, a cap flag and overflow / head-stall watchdog flags.
// Ports:
//   commit_*            commit record input (pushed on en_i & commit_v_i)
//   wb_*                per-RF writeback inputs (pushed on en_i & wb_v_i[r])
//   ret_*, ret_yumi_i   matched record output with pop handshake
//   instr_cap_i         retire count at which cap_reached_o sets (0 = off)
//   instr_cnt_o         retired non-trap, non-debug count (saturating)
//   cap_reached_o, overflow_o, timeout_o   sticky status
//   pending_o           any queue non-empty
module bp_nonsynth_commit_matcher
    import bp_nonsynth_cosim_pkg::*;
#(
    parameter int num_rf_p      = 2,
    parameter int commit_els_p  = 128,
    parameter int wb_els_p      = 16,
    parameter int vaddr_width_p = 39,
    parameter int data_width_p  = 64,
    parameter int timeout_p     = 4096,
    parameter int cnt_width_p   = 31
) (
    input  logic                             clk_i,
    input  logic                             reset_i,
    input  logic                             en_i,
    input  logic                             commit_v_i,
    input  logic                             commit_trap_i,
    input  logic                             commit_debug_i,
    input  logic [vaddr_width_p-1:0]         commit_pc_i,
    input  logic [31:0]                      commit_instr_i,
    input  logic [num_rf_p-1:0]              commit_wb_i,
    input  logic [63:0]                      commit_cause_i,
    input  logic [num_rf_p-1:0]              wb_v_i,
    input  logic [num_rf_p*5-1:0]            wb_addr_i,
    input  logic [num_rf_p*data_width_p-1:0] wb_data_i,
    output logic                             ret_v_o,
    input  logic                             ret_yumi_i,
    output logic                             ret_trap_o,
    output logic                             ret_debug_o,
    output logic [vaddr_width_p-1:0]         ret_pc_o,
    output logic [31:0]                      ret_instr_o,
    output logic [63:0]                      ret_cause_o,
    output logic [num_rf_p-1:0]              ret_wb_o,
    output logic [data_width_p-1:0]          ret_data_o,
    input  logic [cnt_width_p-1:0]           instr_cap_i,
    output logic [cnt_width_p-1:0]           instr_cnt_o,
    output logic                             cap_reached_o,
    output logic                             overflow_o,
    output logic                             timeout_o,
    output logic                             pending_o
);

    localparam int cq_ptr_w = (commit_els_p > 1) ? $clog2(commit_els_p) : 1;
    localparam int cq_cnt_w = $clog2(commit_els_p + 1);
    localparam int stall_w  = $clog2(timeout_p + 1);

    retire_rec_s             cq_mem [commit_els_p];
    retire_rec_s             push_rec, out_rec, last_rec;
    logic [cq_ptr_w-1:0]     cq_wr_ptr, cq_rd_ptr;
    logic [cq_cnt_w-1:0]     cq_count;
    logic                    cq_empty, cq_full, cq_push_req, cq_push, cq_pop, cq_drop;
    logic                    multi_hot;
    logic [stall_w-1:0]      stall_cnt;
    logic [data_width_p-1:0] match_data, last_data;
    logic [num_rf_p-1:0]     bank_head_v, bank_ovf, bank_pending, matched_vec, wb_pop;
    logic [data_width_p-1:0] bank_head_data [num_rf_p];
    logic [4:0]              head_rd;
    logic                    unused_bits;

    assign multi_hot   = |(commit_wb_i & (commit_wb_i - num_rf_p'(1)));
    assign cq_empty    = (cq_count == '0);
    assign cq_full     = (cq_count == cq_cnt_w'(commit_els_p));
    assign cq_push_req = en_i & commit_v_i;
    assign cq_pop      = ret_yumi_i & ret_v_o;
    assign cq_push     = cq_push_req & (~cq_full | cq_pop);
    assign cq_drop     = cq_push_req & cq_full & ~cq_pop;

    always_comb begin
        push_rec                     = '0;
        push_rec.trap                = commit_trap_i;
        push_rec.debug               = commit_debug_i;
        push_rec.cause               = commit_cause_i;
        push_rec.instr               = commit_instr_i;
        push_rec.pc[vaddr_width_p-1:0] = commit_pc_i;
        // An ambiguous destination is flagged and the record treated as no-write.
        push_rec.wb[num_rf_p-1:0]    = multi_hot ? '0 : commit_wb_i;
    end

    always_ff @(posedge clk_i) begin
        if (cq_push) cq_mem[cq_wr_ptr] <= push_rec;
    end

    // With the queue empty the outputs replay the last popped record, which
    // is all-zero after reset.
    assign out_rec     = cq_empty ? last_rec : cq_mem[cq_rd_ptr];
    assign ret_trap_o  = out_rec.trap;
    assign ret_debug_o = out_rec.debug;
    assign ret_cause_o = out_rec.cause;
    assign ret_instr_o = out_rec.instr;
    assign ret_pc_o    = out_rec.pc[vaddr_width_p-1:0];
    assign ret_wb_o    = out_rec.wb[num_rf_p-1:0];
    assign head_rd     = get_rd(out_rec.instr);
    assign unused_bits = ^{out_rec.pc, out_rec.wb};

    for (genvar r = 0; r < num_rf_p; r++) begin : bank
        bp_nonsynth_wb_bank #(
            .wb_els_p     (wb_els_p),
            .data_width_p (data_width_p)
        ) wb_bank (
            .clk_i     (clk_i),
            .reset_i   (reset_i),
            .push_v    (en_i & wb_v_i[r]),
            .push_addr (wb_addr_i[r*5 +: 5]),
            .push_data (wb_data_i[r*data_width_p +: data_width_p]),
            .pop_v     (wb_pop[r]),
            .head_addr (head_rd),
            .head_v    (bank_head_v[r]),
            .head_data (bank_head_data[r]),
            .overflow  (bank_ovf[r]),
            .pending   (bank_pending[r])
        );
    end

    assign matched_vec = cq_empty ? '0 : (ret_wb_o & bank_head_v);
    assign wb_pop      = cq_pop ? matched_vec : '0;
    assign ret_v_o     = ~cq_empty & ((ret_wb_o == '0) | ret_trap_o | (|matched_vec));

    always_comb begin
        match_data = '0;
        for (int r = 0; r < num_rf_p; r++)
            if (matched_vec[r]) match_data = match_data | bank_head_data[r];
    end

    assign ret_data_o = cq_empty ? last_data : match_data;
    assign pending_o  = ~cq_empty | (|bank_pending);

    always_ff @(posedge clk_i or negedge reset_i) begin
        if (!reset_i) begin
            cq_wr_ptr     <= '0;
            cq_rd_ptr     <= '0;
            cq_count      <= '0;
            last_rec      <= '0;
            last_data     <= '0;
            instr_cnt_o   <= '0;
            cap_reached_o <= 1'b0;
            overflow_o    <= 1'b0;
            timeout_o     <= 1'b0;
            stall_cnt     <= '0;
        end else begin
            if (cq_push)
                cq_wr_ptr <= (cq_wr_ptr == cq_ptr_w'(commit_els_p - 1)) ? '0 : cq_wr_ptr + cq_ptr_w'(1);
            if (cq_pop) begin
                cq_rd_ptr <= (cq_rd_ptr == cq_ptr_w'(commit_els_p - 1)) ? '0 : cq_rd_ptr + cq_ptr_w'(1);
                last_rec  <= out_rec;
                last_data <= match_data;
            end
            if (cq_push & ~cq_pop)
                cq_count <= cq_count + cq_cnt_w'(1);
            else if (~cq_push & cq_pop)
                cq_count <= cq_count - cq_cnt_w'(1);

            if (cq_pop & ~ret_trap_o & ~ret_debug_o & (instr_cnt_o != '1))
                instr_cnt_o <= instr_cnt_o + cnt_width_p'(1);
            if ((instr_cap_i != '0) && (instr_cnt_o == instr_cap_i))
                cap_reached_o <= 1'b1;
            if (cq_drop | (cq_push_req & multi_hot) | (|bank_ovf))
                overflow_o <= 1'b1;

            if (cq_pop | cq_empty)
                stall_cnt <= '0;
            else if (~ret_v_o & (stall_cnt != stall_w'(timeout_p)))
                stall_cnt <= stall_cnt + stall_w'(1);
            if (stall_cnt == stall_w'(timeout_p))
                timeout_o <= 1'b1;
        end
    end

endmodule

// File: tb/tb_bp_nonsynth_commit_matcher.sv
// tb/tb_bp_nonsynth_commit_matcher.sv - scoreboard bench for bp_nonsynth_commit_matcher
module tb_bp_nonsynth_commit_matcher;

    localparam int NRF = 2;
    localparam int VA  = 39;
    localparam int DW  = 64;
    localparam int CW  = 31;

    logic              clk_i, reset_i, en_i;
    logic              commit_v_i, commit_trap_i, commit_debug_i;
    logic [VA-1:0]     commit_pc_i;
    logic [31:0]       commit_instr_i;
    logic [NRF-1:0]    commit_wb_i;
    logic [63:0]       commit_cause_i;
    logic [NRF-1:0]    wb_v_i;
    logic [NRF*5-1:0]  wb_addr_i;
    logic [NRF*DW-1:0] wb_data_i;
    logic              ret_v_o, ret_yumi_i, ret_trap_o, ret_debug_o;
    logic [VA-1:0]     ret_pc_o;
    logic [31:0]       ret_instr_o;
    logic [63:0]       ret_cause_o;
    logic [NRF-1:0]    ret_wb_o;
    logic [DW-1:0]     ret_data_o;
    logic [CW-1:0]     instr_cap_i, instr_cnt_o;
    logic              cap_reached_o, overflow_o, timeout_o, pending_o;

    bp_nonsynth_commit_matcher #(
        .num_rf_p(NRF), .commit_els_p(128), .wb_els_p(16), .vaddr_width_p(VA),
        .data_width_p(DW), .timeout_p(4096), .cnt_width_p(CW)
    ) dut (
        .clk_i(clk_i), .reset_i(reset_i), .en_i(en_i),
        .commit_v_i(commit_v_i), .commit_trap_i(commit_trap_i), .commit_debug_i(commit_debug_i),
        .commit_pc_i(commit_pc_i), .commit_instr_i(commit_instr_i), .commit_wb_i(commit_wb_i),
        .commit_cause_i(commit_cause_i), .wb_v_i(wb_v_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
        .ret_v_o(ret_v_o), .ret_yumi_i(ret_yumi_i), .ret_trap_o(ret_trap_o), .ret_debug_o(ret_debug_o),
        .ret_pc_o(ret_pc_o), .ret_instr_o(ret_instr_o), .ret_cause_o(ret_cause_o), .ret_wb_o(ret_wb_o),
        .ret_data_o(ret_data_o), .instr_cap_i(instr_cap_i), .instr_cnt_o(instr_cnt_o),
        .cap_reached_o(cap_reached_o), .overflow_o(overflow_o), .timeout_o(timeout_o), .pending_o(pending_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    typedef struct {
        logic [VA-1:0]  pc;
        logic [DW-1:0]  data;
        logic           trap;
        logic           debug;
        logic [NRF-1:0] wb;
        logic [63:0]    cause;
    } exp_t;

    exp_t          sb[$];
    int            total = 0;
    int            bad = 0;
    int            exp_cnt = 0;
    logic [VA-1:0] last_pc = '0;

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_commit(input logic [VA-1:0] pc, input logic [4:0] rd, input logic [NRF-1:0] wb,
                              input logic trap, input logic debug);
        commit_v_i     = 1'b1;
        commit_pc_i    = pc;
        commit_instr_i = {12'h001, 5'd0, 3'b000, rd, 7'h13};
        commit_wb_i    = wb;
        commit_trap_i  = trap;
        commit_debug_i = debug;
        commit_cause_i = trap ? 64'h8000_0000_0000_0007 : 64'h0;
    endtask

    function automatic exp_t mk_exp(input logic [VA-1:0] pc, input logic [NRF-1:0] wb, input logic trap,
                                    input logic debug, input logic [DW-1:0] data);
        exp_t e;
        e.pc    = pc;
        e.wb    = wb;
        e.trap  = trap;
        e.debug = debug;
        e.data  = data;
        e.cause = trap ? 64'h8000_0000_0000_0007 : 64'h0;
        return e;
    endfunction

    task automatic drive_commit(input logic [VA-1:0] pc, input logic [4:0] rd, input logic [NRF-1:0] wb,
                                input logic trap, input logic debug, input logic [DW-1:0] data);
        set_commit(pc, rd, wb, trap, debug);
        sb.push_back(mk_exp(pc, wb, trap, debug, data));
        step();
        commit_v_i = 1'b0;
    endtask

    task automatic drive_wb(input int rf, input logic [4:0] rd, input logic [DW-1:0] data);
        wb_v_i[rf]             = 1'b1;
        wb_addr_i[rf*5 +: 5]   = rd;
        wb_data_i[rf*DW +: DW] = data;
        step();
        wb_v_i = '0;
    endtask

    task automatic retire(input string tag);
        int   n = 0;
        exp_t e;
        while (!ret_v_o && n < 200) begin
            step();
            n++;
        end
        check({tag, "_ret_v"}, 64'(ret_v_o), 64'd1);
        if (sb.size() == 0) begin
            check({tag, "_sb_nonempty"}, 64'd0, 64'd1);
        end else begin
            e = sb.pop_front();
            check({tag, "_pc"}, 64'(ret_pc_o), 64'(e.pc));
            check({tag, "_data"}, ret_data_o, e.data);
            check({tag, "_trap"}, 64'(ret_trap_o), 64'(e.trap));
            check({tag, "_debug"}, 64'(ret_debug_o), 64'(e.debug));
            check({tag, "_wb"}, 64'(ret_wb_o), 64'(e.wb));
            check({tag, "_cause"}, ret_cause_o, e.cause);
            if (!e.trap && !e.debug) exp_cnt++;
            last_pc = e.pc;
        end
        ret_yumi_i = 1'b1;
        step();
        ret_yumi_i = 1'b0;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    initial begin
        exp_t e;
        reset_i = 1'b0; en_i = 1'b1; commit_v_i = 1'b0; commit_trap_i = 1'b0; commit_debug_i = 1'b0;
        commit_pc_i = '0; commit_instr_i = '0; commit_wb_i = '0; commit_cause_i = '0;
        wb_v_i = '0; wb_addr_i = '0; wb_data_i = '0; ret_yumi_i = 1'b0; instr_cap_i = '0;
        #1;
        check("rst_ret_v", 64'(ret_v_o), 64'd0);
        check("rst_pending", 64'(pending_o), 64'd0);
        check("rst_cnt", 64'(instr_cnt_o), 64'd0);
        check("rst_flags", {61'd0, cap_reached_o, overflow_o, timeout_o}, 64'd0);
        check("rst_pc", 64'(ret_pc_o), 64'd0);
        step(); step();
        reset_i = 1'b1;
        step();

        // Single addi x5, writeback arrives ten cycles later.
        drive_commit(39'h1000, 5'd5, 2'b01, 1'b0, 1'b0, 64'h1234);
        repeat (9) step();
        check("addi_wait_v", 64'(ret_v_o), 64'd0);
        check("addi_wait_data", ret_data_o, 64'd0);
        check("addi_wait_pending", 64'(pending_o), 64'd1);
        drive_wb(0, 5'd5, 64'h1234);
        check("addi_match_v", 64'(ret_v_o), 64'd1);
        retire("addi");
        check("addi_cnt", 64'(instr_cnt_o), 64'(exp_cnt));
        check("addi_cnt_one", 64'(instr_cnt_o), 64'd1);

        // Three commits to x7 ahead of their writebacks, plus an x0 write.
        drive_commit(39'h2000, 5'd7, 2'b01, 1'b0, 1'b0, 64'd1);
        drive_commit(39'h2004, 5'd7, 2'b01, 1'b0, 1'b0, 64'd2);
        drive_commit(39'h2008, 5'd7, 2'b01, 1'b0, 1'b0, 64'd3);
        drive_commit(39'h200c, 5'd0, 2'b01, 1'b0, 1'b0, 64'h55);
        check("x7_blocked", 64'(ret_v_o), 64'd0);
        drive_wb(0, 5'd7, 64'd1);
        drive_wb(0, 5'd7, 64'd2);
        drive_wb(0, 5'd7, 64'd3);
        drive_wb(0, 5'd0, 64'h55);
        for (int i = 0; i < 4; i++) retire("x7");
        check("x7_cnt", 64'(instr_cnt_o), 64'(exp_cnt));
        check("x7_empty", 64'(pending_o), 64'd0);

        // Reset with five records pending, asserted between clock edges.
        for (int i = 0; i < 5; i++) drive_commit(39'h4000 + 39'(i * 4), 5'd9, 2'b00, 1'b0, 1'b0, 64'd0);
        sb.delete();
        check("prerst_pending", 64'(pending_o), 64'd1);
        check("prerst_v", 64'(ret_v_o), 64'd1);
        #2;
        reset_i = 1'b0;
        #1;
        check("midrst_pending", 64'(pending_o), 64'd0);
        check("midrst_v", 64'(ret_v_o), 64'd0);
        check("midrst_pc", 64'(ret_pc_o), 64'd0);
        check("midrst_cnt", 64'(instr_cnt_o), 64'd0);
        exp_cnt = 0;
        step();
        reset_i = 1'b1;
        step();

        // Instruction cap: trap and debug records are not counted.
        instr_cap_i = 3;
        drive_commit(39'h3000, 5'd1, 2'b00, 1'b1, 1'b0, 64'd0);
        drive_commit(39'h3004, 5'd1, 2'b00, 1'b0, 1'b1, 64'd0);
        drive_commit(39'h3008, 5'd1, 2'b00, 1'b0, 1'b0, 64'd0);
        drive_commit(39'h300c, 5'd1, 2'b00, 1'b0, 1'b0, 64'd0);
        drive_commit(39'h3010, 5'd1, 2'b00, 1'b0, 1'b0, 64'd0);
        for (int i = 0; i < 4; i++) retire("cap");
        check("cap_cnt2", 64'(instr_cnt_o), 64'd2);
        check("cap_not_yet", 64'(cap_reached_o), 64'd0);
        retire("cap");
        check("cap_cnt3", 64'(instr_cnt_o), 64'd3);
        check("cap_same_cycle", 64'(cap_reached_o), 64'd0);
        step();
        check("cap_reached", 64'(cap_reached_o), 64'd1);

        // Fill the commit queue, then push-with-pop at full, then a dropped push.
        for (int i = 0; i < 128; i++) drive_commit(39'h10000 + 39'(i * 4), 5'd1, 2'b00, 1'b0, 1'b0, 64'd0);
        check("full_no_ovf", 64'(overflow_o), 64'd0);
        e = sb.pop_front();
        check("full_head_pc", 64'(ret_pc_o), 64'(e.pc));
        exp_cnt++;
        set_commit(39'h20000, 5'd1, 2'b00, 1'b0, 1'b0);
        sb.push_back(mk_exp(39'h20000, 2'b00, 1'b0, 1'b0, 64'd0));
        ret_yumi_i = 1'b1;
        step();
        ret_yumi_i = 1'b0;
        commit_v_i = 1'b0;
        check("pushpop_no_ovf", 64'(overflow_o), 64'd0);
        set_commit(39'h0dead0, 5'd1, 2'b00, 1'b0, 1'b0);
        step();
        commit_v_i = 1'b0;
        check("drop_ovf", 64'(overflow_o), 64'd1);
        for (int i = 0; i < 128; i++) retire("drain");
        check("drain_v", 64'(ret_v_o), 64'd0);
        check("drain_pending", 64'(pending_o), 64'd0);
        check("drain_hold_pc", 64'(ret_pc_o), 64'(last_pc));
        check("drain_cnt", 64'(instr_cnt_o), 64'(exp_cnt));

        // Fp commit with no writeback trips the head-stall watchdog.
        drive_commit(39'h5000, 5'd3, 2'b10, 1'b0, 1'b0, 64'habcd);
        repeat (4090) step();
        check("tmo_early", 64'(timeout_o), 64'd0);
        check("tmo_blocked", 64'(ret_v_o), 64'd0);
        repeat (10) step();
        check("tmo_set", 64'(timeout_o), 64'd1);
        drive_wb(1, 5'd3, 64'habcd);
        retire("fp");
        check("tmo_sticky", 64'(timeout_o), 64'd1);
        check("fp_pending", 64'(pending_o), 64'd0);
        check("sb_drained", 64'(sb.size()), 64'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/bp_nonsynth_commit_matcher.md
BP_NONSYNTH_COMMIT_MATCHER -- requirements
Module: bp_nonsynth_commit_matcher

Interface
REQ-001 Parameters SHALL be:
- num_rf_p, default 2: register-file channel count (0 = int, 1 = fp).
- commit_els_p, default 128: commit queue depth.
- wb_els_p, default 16: per-register writeback queue depth.
- vaddr_width_p, default 39: PC width.
- data_width_p, default 64: writeback data width.
- timeout_p, default 4096: head-stall watchdog limit, in cycles.
- cnt_width_p, default 31: instruction counter width.
REQ-002 Ports SHALL be (name  direction  width  meaning):
- clk_i  in  1  clock.
- reset_i  in  1  reset; asynchronous, active-low.
- en_i  in  1  enables pushes.
- commit_v_i  in  1  commit record valid.
- commit_trap_i  in  1  record is exception/interrupt.
- commit_debug_i  in  1  record retired in debug mode.
- commit_pc_i  in  vaddr_width_p  PC.
- commit_instr_i  in  32  instruction.
- commit_wb_i  in  num_rf_p  one-hot, RF expected to write rd.
- commit_cause_i  in  64  trap cause.
- wb_v_i  in  num_rf_p  per-RF writeback valid.
- wb_addr_i  in  num_rf_p*5  per-RF rd.
- wb_data_i  in  num_rf_p*data_width_p  per-RF data.
- ret_v_o  out  1  matched record available.
- ret_yumi_i  in  1  consumer pops record.
- ret_trap_o  out  1  record is a trap.
- ret_debug_o  out  1  record retired in debug mode.
- ret_pc_o  out  vaddr_width_p  PC.
- ret_instr_o  out  32  instruction.
- ret_cause_o  out  64  trap cause.
- ret_wb_o  out  num_rf_p  one-hot RF written.
- ret_data_o  out  data_width_p  matched data, 0 if none.
- instr_cap_i  in  cnt_width_p  cap; 0 disables.
- instr_cnt_o  out  cnt_width_p  retired count.
- cap_reached_o  out  1  sticky.
- overflow_o  out  1  sticky.
- timeout_o  out  1  sticky.
- pending_o  out  1  any queue non-empty.

Function
REQ-003 Commit record SHALL be pushed when en_i & commit_v_i; a record pushed at cycle t is visible on ret_* at t+1 at the earliest.
REQ-004 For each RF r and rd 0..31, a FIFO of depth wb_els_p SHALL be pushed when en_i & wb_v_i[r] & wb_addr_i[r]==rd; rd=0 is queued like any other register.
REQ-005 ret_v_o SHALL be asserted when:
- the head is valid; and
- ret_wb_o==0, or ret_trap_o==1, or wb FIFO[r][instr[11:7]] is non-empty, where r is the set bit of ret_wb_o.
REQ-006 ret_data_o SHALL be the head of wb FIFO[r][rd] when a writeback is matched, else 0.
REQ-007 ret_yumi_i SHALL only be asserted with ret_v_o; it pops the commit head and, if matched, the wb FIFO head in the same cycle.
REQ-008 Push and pop on the same queue in the same cycle SHALL both succeed, including when the queue is full.
REQ-009 A push to a full queue without a simultaneous pop SHALL be dropped and set overflow_o.
REQ-010 A commit_wb_i with more than one bit set SHALL set overflow_o and be treated as 0.
REQ-011 Empty commit queue SHALL give ret_v_o=0 with ret_* held at their last value.
REQ-012 instr_cnt_o SHALL increment on ret_yumi_i & ~ret_trap_o & ~ret_debug_o and saturate at 2^cnt_width_p-1.
REQ-013 cap_reached_o SHALL set the cycle after instr_cnt_o==instr_cap_i while instr_cap_i!=0.
REQ-014 Stall counter SHALL increment each cycle the head is valid and ret_v_o==0, clear on pop or when the queue is empty, and set timeout_o on reaching timeout_p; it saturates there.
REQ-015 pending_o SHALL be the OR of all queue non-empty flags.

Reset
REQ-016 reset_i low SHALL asynchronously:
- empty all queues;
- clear instr_cnt_o, the stall counter, and all sticky flags;
- force ret_v_o=0 and ret_* to 0.
REQ-017 Reset asserted mid-operation SHALL discard in-flight records; no pop is reported in that cycle.

Structure
REQ-018 Retire record struct, RF index constants (int=0, fp=1) and rd field offset SHALL live in bp_nonsynth_cosim_pkg.
REQ-019 One sub-module, bp_nonsynth_wb_bank, SHALL hold the 32 FIFOs of one RF and be instantiated num_rf_p times.
REQ-020 The block SHALL contain no DPI calls; it is usable under any simulator.

Verification
REQ-021 Commit addi x5 (wb=01) at t=0, int wb x5=0x1234 at t=10 -> ret_v_o at t=11, ret_data_o=0x1234, instr_cnt_o=1 after pop.
REQ-022 Three commits to x7 arriving before writebacks 1,2,3, then the three writebacks -> retired in order with data 1,2,3.
REQ-023 Fp commit (wb=10) with no fp wb for 4096 cycles -> timeout_o=1; late wb then pop -> timeout_o stays 1.
REQ-024 Fill commit queue to 128, push one more with no pop -> overflow_o=1, record dropped; push with a simultaneous pop -> accepted, no overflow.
REQ-025 instr_cap_i=3, retire trap, debug and 3 normal records -> instr_cnt_o=3, cap_reached_o=1 one cycle later.
REQ-026 reset_i low with 5 records pending -> pending_o=0, ret_v_o=0 immediately, without a clock edge.
